// File: rtl/router_arith_pkg.sv
// Shared arithmetic definitions for the router datapath blocks:
// arithmetic mode selectors and the accumulator FSM state type.
package router_arith_pkg;

   localparam int MODE_WRAP = 0;  // modular sum, carries discarded
   localparam int MODE_ONES = 1;  // ones-complement sum, end-around carry
   localparam int MODE_SAT  = 2;  // saturating sum, sticks at all-ones

   typedef enum logic {
      ACCUM = 1'b0,   // collecting operands of a packet
      HOLD  = 1'b1    // result presented, waiting for the consumer
   } state_t;

endpackage

// File: rtl/stream_sum_accumulator_adder.sv
// Plain combinational adder: two size-bit operands give a size+1 bit sum
// whose top bit is the carry out.
module stream_sum_accumulator_adder #(
   parameter int size = 8
) (
   input  logic [size-1:0] a,
   input  logic [size-1:0] b,
   output logic [size:0]   s
);

   assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/stream_sum_accumulator.sv
// Packet sum accumulator. Operands arrive on a valid/ready stream and are
// folded into one sum per packet (delimited by in_last). The result, a
// sticky overflow flag and a saturating operand count are presented on a
// valid/ready output; no new operand is accepted until the result is taken.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and a producer that raises valid
// keeps it and its payload stable until the transfer.
module stream_sum_accumulator
   import router_arith_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SIZE-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SIZE-1:0]  out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   state_t             state;
   state_t             state_nxt;
   logic               first;
   logic [SIZE-1:0]    acc;
   logic               ovf;
   logic [CNT_W-1:0]   cnt;
   logic [SIZE:0]      s;
   logic               carry;
   logic [SIZE-1:0]    acc_nxt;
   logic               in_fire;
   logic               out_fire;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   stream_sum_accumulator_adder #(
      .size (SIZE)
   ) u_adder (
      .a (acc),
      .b (in_data),
      .s (s)
   );

   assign carry = s[SIZE];

   // Fold the raw sum into the accumulator according to the arithmetic mode.
   always_comb begin
      acc_nxt = s[SIZE-1:0];
      case (MODE)
         MODE_ONES: acc_nxt = s[SIZE-1:0] + {{(SIZE-1){1'b0}}, carry};
         MODE_SAT:  acc_nxt = carry ? {SIZE{1'b1}} : s[SIZE-1:0];
         default:   acc_nxt = s[SIZE-1:0];
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a last beat closes the packet, a consumer accept reopens.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (in_fire && in_last) state_nxt = HOLD;
         HOLD:    if (out_fire)           state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Handshake outputs decoded from the state alone.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM:   in_ready  = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Accumulator, overflow, count and first-beat flag; a new packet's first
   // beat overwrites whatever the previous packet left behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         first <= 1'b1;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else if (in_fire) begin
         first <= 1'b0;
         if (first) begin
            acc <= in_data;
            ovf <= 1'b0;
            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            acc <= acc_nxt;
            ovf <= ovf | carry;
            if (cnt != {CNT_W{1'b1}}) begin
               cnt <= cnt + 1'b1;
            end
         end
      end else if (out_fire) begin
         first <= 1'b1;
      end
   end

   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign out_count = cnt;

endmodule

// File: tb/tb_stream_sum_accumulator.sv
// Bench for stream_sum_accumulator: four instances (modular, ones-complement,
// saturating, and modular with a 2-bit count) driven from directed vector
// tables, hand-written corner sequences and random packets checked against
// an arithmetic reference model.
module tb_stream_sum_accumulator;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid [4];
   logic       in_ready [4];
   logic [7:0] in_data  [4];
   logic       in_last  [4];
   logic       out_valid[4];
   logic       out_ready[4];
   logic [7:0] out_sum  [4];
   logic       out_ovf  [4];
   logic [7:0] out_count[4];
   logic [1:0] count2;

   int checks = 0;
   int errors = 0;

   localparam int MODE_OF[4] = '{0, 1, 2, 0};
   localparam int CW_OF[4]   = '{8, 8, 8, 2};

   always #5 clk = ~clk;

   stream_sum_accumulator #(.SIZE(8), .MODE(0), .CNT_W(8)) u_wrap (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
      .out_ovf(out_ovf[0]), .out_count(out_count[0]));

   stream_sum_accumulator #(.SIZE(8), .MODE(1), .CNT_W(8)) u_ones (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1]),
      .out_ovf(out_ovf[1]), .out_count(out_count[1]));

   stream_sum_accumulator #(.SIZE(8), .MODE(2), .CNT_W(8)) u_sat (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(out_sum[2]),
      .out_ovf(out_ovf[2]), .out_count(out_count[2]));

   stream_sum_accumulator #(.SIZE(8), .MODE(0), .CNT_W(2)) u_cnt2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]), .in_last(in_last[3]),
      .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_sum(out_sum[3]),
      .out_ovf(out_ovf[3]), .out_count(count2));

   assign out_count[3] = {6'b0, count2};

   // ---------------- scoreboard ----------------
   logic [7:0] pkt_q[$];     // operands of the packet being sent
   logic [7:0] exp_q[$];     // expected sums, oldest first

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: true running sum of the operands, reduced per mode rules.
   function automatic void model(input int mode, input int cw,
                                 output logic [7:0] s, output logic o, output int c);
      int acc;
      int t;
      o   = 1'b0;
      acc = int'(pkt_q[0]);
      for (int i = 1; i < pkt_q.size(); i++) begin
         t = acc + int'(pkt_q[i]);
         if (t > 255) begin
            o = 1'b1;
            if (mode == 0)      t = t - 256;
            else if (mode == 1) t = t - 255;
            else                t = 255;
         end
         acc = t;
      end
      s = acc[7:0];
      c = (pkt_q.size() > (1 << cw) - 1) ? (1 << cw) - 1 : pkt_q.size();
   endfunction

   // ---------------- drivers ----------------
   // Called at a falling edge; presents one beat and returns at the falling
   // edge after it was accepted.
   task automatic beat(input int k, input logic [7:0] d, input logic l);
      int t = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      in_last[k]  = l;
      while (!in_ready[k] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready[k]) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;
   endtask

   // Waits for a result, holds it off for 'hold' cycles, then accepts it.
   task automatic get_result(input int k, input string nm, input logic [7:0] es,
                             input logic eo, input int ec, input int hold);
      int t = 0;
      while (!out_valid[k] && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_valid"}, int'(out_valid[k]), 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_valid"}, int'(out_valid[k]), 1);
         chk({nm, "_hold_ready"}, int'(in_ready[k]), 0);
      end
      chk({nm, "_sum"}, int'(out_sum[k]), int'(es));
      chk({nm, "_ovf"}, int'(out_ovf[k]), int'(eo));
      chk({nm, "_count"}, int'(out_count[k]), ec);
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk({nm, "_valid_drop"}, int'(out_valid[k]), 0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int              k;
      int              n;
      logic [5:0][7:0] d;
      logic [7:0]      sum;
      logic            ovf;
      int              cnt;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] es;
      logic       eo;
      int         ec;
      int         n;

      vecs[0] = '{k:0, n:3, d:{8'h00, 8'h00, 8'h00, 8'h10, 8'h90, 8'h80}, sum:8'h20, ovf:1'b1, cnt:3};
      vecs[1] = '{k:1, n:2, d:{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF}, sum:8'h01, ovf:1'b1, cnt:2};
      vecs[2] = '{k:1, n:2, d:{8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12}, sum:8'h46, ovf:1'b0, cnt:2};
      vecs[3] = '{k:2, n:3, d:{8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 8'hF0}, sum:8'hFF, ovf:1'b1, cnt:3};
      vecs[4] = '{k:3, n:5, d:{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01}, sum:8'h05, ovf:1'b0, cnt:3};
      vecs[5] = '{k:0, n:1, d:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, sum:8'hA5, ovf:1'b0, cnt:1};
      vecs[6] = '{k:2, n:2, d:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, sum:8'hFF, ovf:1'b0, cnt:2};

      // clock / reset
      for (int k = 0; k < 4; k++) begin
         in_valid[k] = 1'b0; in_data[k] = 8'h00; in_last[k] = 1'b0; out_ready[k] = 1'b0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("rst_in_ready", int'(in_ready[k]), 1);
         chk("rst_out_valid", int'(out_valid[k]), 0);
         chk("rst_out_sum", int'(out_sum[k]), 0);
         chk("rst_out_ovf", int'(out_ovf[k]), 0);
         chk("rst_out_count", int'(out_count[k]), 0);
      end

      // table-driven packets
      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            beat(vecs[v].k, vecs[v].d[i], i == vecs[v].n - 1);
         end
         get_result(vecs[v].k, $sformatf("vec%0d", v), vecs[v].sum, vecs[v].ovf, vecs[v].cnt, 0);
      end

      // backpressure: result held while a new beat waits on in_valid
      beat(0, 8'h05, 1'b1);
      in_valid[0] = 1'b1; in_data[0] = 8'h07; in_last[0] = 1'b1;
      get_result(0, "bp_first", 8'h05, 1'b0, 1, 5);
      chk("bp_ready_back", int'(in_ready[0]), 1);
      beat(0, 8'h07, 1'b1);
      get_result(0, "bp_second", 8'h07, 1'b0, 1, 0);

      // reset in the middle of a packet discards the partial sum
      beat(0, 8'h11, 1'b0);
      beat(0, 8'h22, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_out_count", int'(out_count[0]), 0);
      beat(0, 8'h05, 1'b1);
      get_result(0, "midrst", 8'h05, 1'b0, 1, 0);

      // random packets against the reference model
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 6);
            pkt_q.delete();
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            model(MODE_OF[k], CW_OF[k], es, eo, ec);
            exp_q.push_back(es);
            for (int i = 0; i < n; i++) begin
               repeat ($urandom_range(0, 1)) @(negedge clk);
               beat(k, pkt_q[i], i == n - 1);
            end
            get_result(k, $sformatf("rnd_k%0d_p%0d", k, p), exp_q.pop_front(), eo, ec,
                       $urandom_range(0, 2));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_sum_accumulator.md
Name: stream_sum_accumulator

Overview:
- Parametrised successor to the team's combinational adder.
- Accumulates a stream of SIZE-bit operands under valid/ready handshake, delimited by a last flag, and emits one sum per packet.
- Three arithmetic modes: modular, ones-complement (end-around carry) and saturating.
- Sits on the router datapath after SPI byte reassembly; used for packet checksums and length/metric totals.

Parameters:
- SIZE, 8, operand and sum width in bits.
- MODE, 0, arithmetic mode: 0 = modular (wrap), 1 = ones-complement end-around carry, 2 = saturating at all-ones.
- CNT_W, 8, width of the operand-count output; the count saturates at all-ones.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  SIZE  operand.
- in_last  input  1  final operand of the packet; qualified by in_valid && in_ready.
- out_valid  output  1  packet result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  SIZE  packet sum per MODE.
- out_ovf  output  1  sticky flag: a carry out of bit SIZE-1 (or saturation) occurred during the packet.
- out_count  output  CNT_W  number of operands accepted in the packet, saturating.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to ACCUM; internal first-flag is set; acc, ovf and cnt clear to 0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_count=0.
  - A partial packet in progress is discarded.
  - reset has priority over every other event in the same cycle.
- FSM has two states: ACCUM and HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - A beat is accepted on in_valid && in_ready.
  - First beat of a packet: acc <= in_data, ovf <= 0, cnt <= 1.
  - Later beats: acc <= f(acc, in_data), ovf <= ovf | carry, cnt <= cnt+1 saturating at 2^CNT_W-1.
  - If in_last is set on an accepted beat: go to HOLD and clear the first-flag requirement for the next packet.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_sum, out_ovf and out_count hold acc, ovf and cnt, stable until accepted.
  - When out_ready=1: go to ACCUM, set first-flag, out_valid drops on the next cycle.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N. The minimum packet period is therefore (beats+1) cycles.
- No overlap between packets: in_ready=0 while a result is pending. in_valid asserted in HOLD is ignored and must be held by the producer.
- Arithmetic: s = {1'b0,acc} + {1'b0,in_data}, which is SIZE+1 bits; carry = s[SIZE].
  - MODE 0: acc <= s[SIZE-1:0].
  - MODE 1: acc <= s[SIZE-1:0] + carry. The end-around add cannot produce a second carry.
  - MODE 2: acc <= carry ? all-ones : s[SIZE-1:0]. Once at all-ones the value stays there.
- Single-beat packet (first and last on the same beat): out_sum=in_data, out_ovf=0, out_count=1.
- A beat with in_last=0 and in_valid=0 has no effect; idle cycles inside a packet are allowed.
- out_* values are don't-care when out_valid=0, but they are driven with registered values (no X).

Decomposition:
- Shared package router_arith_pkg holds:
  - mode constants MODE_WRAP=0, MODE_ONES=1, MODE_SAT=2;
  - the FSM state typedef {ACCUM, HOLD}.
- One sub-module: the existing adder module instantiated with size=SIZE produces the SIZE+1 bit sum s.
- End-around carry, saturation, FSM and counters live in stream_sum_accumulator.

Test Plan:
- MODE0, SIZE8: beats 0x80, 0x90, 0x10(last) with out_ready=1 -> out_sum=0x20, out_ovf=1, out_count=3, out_valid high for exactly 1 cycle.
- MODE1: beats 0xFF, 0x01(last) -> out_sum=0x01, out_ovf=1. Then beats 0x12, 0x34(last) -> out_sum=0x46, out_ovf=0, out_count=2.
- MODE2: beats 0xF0, 0x20, 0x01(last) -> out_sum=0xFF, out_ovf=1, out_count=3.
- Backpressure: 0x05(last) with out_ready=0 for 5 cycles, in_valid held high with 0x07 -> out_sum=0x05 stable, in_ready=0 throughout. After the accept, the next packet starts with 0x07.
- Reset mid-packet: beats 0x11, 0x22, then reset=1 for 1 cycle, then 0x05(last) -> out_sum=0x05, out_count=1, out_ovf=0.
- CNT_W=2: five beats of 0x01, last on the 5th -> out_sum=0x05, out_count=3 (saturated), out_ovf=0.
